// File: rtl/mult_pkg.sv
// Shared definitions for the Booth multiplier: default width, step-counter
// width and the FSM state encoding.
package mult_pkg;

    localparam int unsigned MULT_WIDTH = 32;
    localparam int unsigned MULT_CNT_W = $clog2(MULT_WIDTH) + 1;

    typedef enum logic [1:0] {
        MULT_IDLE = 2'd0,
        MULT_RUN  = 2'd1,
        MULT_DONE = 2'd2
    } mult_state_t;

endpackage : mult_pkg

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of the multiplicand
// into ACC, followed by an arithmetic right shift of {ACC,Q,Q-1}.
module booth_step
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH
) (
    input  logic [WIDTH:0]   acc,
    input  logic [WIDTH-1:0] q,
    input  logic             q_m1,
    input  logic [WIDTH:0]   m,
    output logic [WIDTH:0]   acc_c,
    output logic [WIDTH-1:0] q_c,
    output logic             q_m1_c
);

    logic [WIDTH:0] sum;

    // Recode {Q[0],Q-1} into +M / -M / 0, then shift the whole triple right.
    always_comb begin
        sum = acc;
        case ({q[0], q_m1})
            2'b01:   sum = acc + m;
            2'b10:   sum = acc - m;
            default: sum = acc;
        endcase
        acc_c  = {sum[WIDTH], sum[WIDTH:1]};
        q_c    = {sum[0], q[WIDTH-1:1]};
        q_m1_c = q[0];
    end

endmodule : booth_step

// File: rtl/booth_multiplier.sv
// Sequential signed WIDTHxWIDTH radix-2 Booth multiplier feeding HI/LO.
// Optional feature: define MULT_ZERO_SKIP_EN to finish in one cycle when
// either operand is zero at acceptance.
module booth_multiplier
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             done,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    localparam logic [1:0] ST_IDLE = 2'(MULT_IDLE);
    localparam logic [1:0] ST_RUN  = 2'(MULT_RUN);
    localparam logic [1:0] ST_DONE = 2'(MULT_DONE);

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    logic [1:0]       state, state_nxt;
    logic [WIDTH:0]   acc, acc_nxt;
    logic [WIDTH:0]   m, m_nxt;
    logic [WIDTH-1:0] q, q_nxt;
    logic             q_m1, q_m1_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic [WIDTH-1:0] hi_nxt, lo_nxt;
    logic             done_nxt, busy_nxt;

    logic [WIDTH:0]   acc_step_c;
    logic [WIDTH-1:0] q_step_c;
    logic             q_m1_step_c;
    logic             zero_skip_c;

    booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc    (acc),
        .q      (q),
        .q_m1   (q_m1),
        .m      (m),
        .acc_c  (acc_step_c),
        .q_c    (q_step_c),
        .q_m1_c (q_m1_step_c)
    );

`ifdef MULT_ZERO_SKIP_EN
    // A zero operand makes the product trivially zero; skip the iterations.
    assign zero_skip_c = (a == '0) || (b == '0);
`else
    assign zero_skip_c = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, datapath and output-register next values.
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        m_nxt     = m;
        q_nxt     = q;
        q_m1_nxt  = q_m1;
        count_nxt = count;
        hi_nxt    = hi;
        lo_nxt    = lo;
        done_nxt  = 1'b0;
        busy_nxt  = busy;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    busy_nxt = 1'b1;
                    if (zero_skip_c) begin
                        hi_nxt    = '0;
                        lo_nxt    = '0;
                        done_nxt  = 1'b1;
                        state_nxt = ST_DONE;
                    end else begin
                        m_nxt     = {a[WIDTH-1], a};
                        q_nxt     = b;
                        q_m1_nxt  = 1'b0;
                        acc_nxt   = '0;
                        count_nxt = '0;
                        state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                acc_nxt   = acc_step_c;
                q_nxt     = q_step_c;
                q_m1_nxt  = q_m1_step_c;
                count_nxt = CNT_W'(count + 1'b1);
                if (count == LAST_STEP) begin
                    hi_nxt    = acc_step_c[WIDTH-1:0];
                    lo_nxt    = q_step_c;
                    done_nxt  = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_nxt  = 1'b0;
                state_nxt = ST_IDLE;
            end
            default: begin
                busy_nxt  = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath and output registers; reset discards any partial product.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc   <= '0;
            m     <= '0;
            q     <= '0;
            q_m1  <= 1'b0;
            count <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            acc   <= acc_nxt;
            m     <= m_nxt;
            q     <= q_nxt;
            q_m1  <= q_m1_nxt;
            count <= count_nxt;
            hi    <= hi_nxt;
            lo    <= lo_nxt;
            done  <= done_nxt;
            busy  <= busy_nxt;
        end
    end

endmodule : booth_multiplier

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier: directed corner cases plus
// randomized operands against a plain signed-multiply reference.
module tb_booth_multiplier;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             done;
    logic             busy;

    int n_cmp;
    int n_err;
    logic [WIDTH-1:0] prev_hi;
    logic [WIDTH-1:0] prev_lo;

    booth_multiplier #(
        .WIDTH (WIDTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .hi    (hi),
        .lo    (lo),
        .done  (done),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_cmp++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, want);
        end
    endtask

    // Expected latency in cycles from the accepting edge to the done cycle.
    function automatic int expected_latency(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b);
        int lat;
        lat = WIDTH + 1;
`ifdef MULT_ZERO_SKIP_EN
        if (op_a == '0 || op_b == '0) lat = 1;
`endif
        return lat;
    endfunction

    // One full multiply; optionally pulses a competing start at cycle poke_at.
    task automatic run_op(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                          input int poke_at, input string tag);
        longint prod;
        int     lat;
        int     extra;
        prod = longint'($signed(op_a)) * longint'($signed(op_b));

        @(negedge clk);
        a     = op_a;
        b     = op_b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        @(negedge clk);
        lat = 1;
        check_value({tag, "_busy_accept"}, 64'(busy), 64'd1);

        while (done !== 1'b1 && lat < 100) begin
            if (lat == 2) begin
                check_value({tag, "_hi_hold"}, 64'(hi), 64'(prev_hi));
                check_value({tag, "_lo_hold"}, 64'(lo), 64'(prev_lo));
            end
            if (lat == poke_at) begin
                a     = 32'd7;
                b     = 32'd7;
                start = 1'b1;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            @(negedge clk);
            lat++;
        end

        check_value({tag, "_latency"}, 64'(lat), 64'(expected_latency(op_a, op_b)));
        check_value({tag, "_hi"}, 64'(hi), 64'(prod[63:32]));
        check_value({tag, "_lo"}, 64'(lo), 64'(prod[31:0]));
        check_value({tag, "_busy_done"}, 64'(busy), 64'd1);
        prev_hi = prod[63:32];
        prev_lo = prod[31:0];

        @(negedge clk);
        check_value({tag, "_done_pulse"}, 64'(done), 64'd0);
        check_value({tag, "_busy_idle"}, 64'(busy), 64'd0);

        if (poke_at > 0) begin
            extra = 0;
            repeat (40) begin
                @(negedge clk);
                if (done === 1'b1) extra++;
            end
            check_value({tag, "_no_extra_done"}, 64'(extra), 64'd0);
            check_value({tag, "_hi_kept"}, 64'(hi), 64'(prev_hi));
        end
    endtask

    // Reset asserted mid-operation: outputs clear and no done ever appears.
    task automatic run_reset_abort(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b);
        int extra;
        @(negedge clk);
        a     = op_a;
        b     = op_b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(negedge clk);
        reset = 1'b1;
        #1;
        check_value("rst_hi", 64'(hi), 64'd0);
        check_value("rst_lo", 64'(lo), 64'd0);
        check_value("rst_busy", 64'(busy), 64'd0);
        check_value("rst_done", 64'(done), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        check_value("rst_no_done", 64'(extra), 64'd0);
        check_value("rst_busy_after", 64'(busy), 64'd0);
        prev_hi = '0;
        prev_lo = '0;
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        n_cmp   = 0;
        n_err   = 0;
        prev_hi = '0;
        prev_lo = '0;
        reset   = 1'b1;
        start   = 1'b0;
        a       = '0;
        b       = '0;

        #12;
        check_value("reset_hi", 64'(hi), 64'd0);
        check_value("reset_lo", 64'(lo), 64'd0);
        check_value("reset_done", 64'(done), 64'd0);
        check_value("reset_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op(32'd3, 32'd4, 0, "3x4");
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "m1xm1");
        run_op(32'h8000_0000, 32'h8000_0000, 0, "minxmin");
        run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 0, "maxxm1");
        run_op(32'd5, 32'd6, 10, "5x6_poke");
        run_op(32'd0, 32'h0000_1234, 0, "zero_a");
        run_op(32'h0000_1234, 32'd0, 0, "zero_b");
        run_reset_abort(32'h1234_5679, 32'hDEAD_BEEF);
        run_op(32'hFFFF_FFF9, 32'd13, 0, "recover");

        for (int i = 0; i < 25; i++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) ra = '0;
            if ($urandom_range(0, 9) == 0) rb = 32'h8000_0000;
            run_op(ra, rb, 0, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_booth_multiplier
